// File: rtl/systolic_pkg.sv
// Shared types and helpers for the N x N weight-stationary systolic array.
// Q8.8 data, FRAC_BITS fractional bits, and the column-enable mask builder.
package systolic_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int MAX_N     = 16;

    typedef logic signed [DATA_W-1:0] data_t;

    // Enable mask for `size` active columns, clamped to an n-column array.
    function automatic logic [MAX_N-1:0] col_mask(
        input logic [31:0] size,
        input int unsigned n
    );
        logic [MAX_N-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            m[i] = (i < n) && (i < size);
        end
        return m;
    endfunction

endpackage

// File: rtl/systolic_array_nxn_if.sv
// Bus between the unified-buffer read path and the systolic array.
// master drives activations/weights/controls; slave is the array.
interface systolic_array_nxn_if #(
    parameter int N          = 2,
    parameter int DATA_W     = 16,
    parameter int COL_SIZE_W = 16
);
    import systolic_pkg::*;

    logic [N*DATA_W-1:0]   sys_data_in;
    logic                  sys_start;
    logic [N*DATA_W-1:0]   sys_weight_in;
    logic [N-1:0]          sys_accept_w;
    logic                  sys_switch_in;
    logic [COL_SIZE_W-1:0] ub_rd_col_size_in;
    logic                  ub_rd_col_size_valid_in;
    logic [N*DATA_W-1:0]   sys_data_out;
    logic [N-1:0]          sys_valid_out;

    modport master (
        output sys_data_in,
        output sys_start,
        output sys_weight_in,
        output sys_accept_w,
        output sys_switch_in,
        output ub_rd_col_size_in,
        output ub_rd_col_size_valid_in,
        input  sys_data_out,
        input  sys_valid_out
    );

    modport slave (
        input  sys_data_in,
        input  sys_start,
        input  sys_weight_in,
        input  sys_accept_w,
        input  sys_switch_in,
        input  ub_rd_col_size_in,
        input  ub_rd_col_size_valid_in,
        output sys_data_out,
        output sys_valid_out
    );

endinterface

// File: rtl/systolic_array_nxn_pe.sv
// One processing element: registered MAC with shadow/active weight pair.
// Activation/valid/switch go east; psum/weight/accept go south.
module pe #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     col_en_i,
    input  logic signed [DATA_W-1:0] act_i,
    input  logic                     vld_i,
    input  logic                     sw_i,
    input  logic signed [DATA_W-1:0] psum_i,
    input  logic signed [DATA_W-1:0] w_i,
    input  logic                     acc_i,
    output logic signed [DATA_W-1:0] act_o,
    output logic                     vld_o,
    output logic                     sw_o,
    output logic signed [DATA_W-1:0] psum_o,
    output logic signed [DATA_W-1:0] w_o,
    output logic                     acc_o,
    output logic                     res_vld_o
);
    import systolic_pkg::*;

    logic signed [DATA_W-1:0]   act_q;
    logic                       vld_q;
    logic                       sw_q;
    logic signed [DATA_W-1:0]   psum_q;
    logic signed [DATA_W-1:0]   psum_d;
    logic signed [DATA_W-1:0]   w_q;
    logic                       acc_q;
    logic                       rvld_q;
    logic signed [DATA_W-1:0]   shadow_q;
    logic signed [DATA_W-1:0]   shadow_d;
    logic signed [DATA_W-1:0]   active_q;
    logic signed [DATA_W-1:0]   active_d;
    logic signed [DATA_W-1:0]   eff_w;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   prod_t;
    logic                       unused_prod;

    // A switch arriving with the data uses the freshly copied weight.
    always_comb begin
        eff_w    = sw_i ? shadow_q : active_q;
        prod     = act_i * eff_w;
        prod_t   = prod[FRAC_BITS +: DATA_W];
        psum_d   = col_en_i ? psum_i + prod_t : '0;
        shadow_d = (acc_i && col_en_i) ? w_i : shadow_q;
        active_d = sw_i ? shadow_q : active_q;
    end

    assign unused_prod = ^prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q    <= '0;
            vld_q    <= 1'b0;
            sw_q     <= 1'b0;
            psum_q   <= '0;
            w_q      <= '0;
            acc_q    <= 1'b0;
            rvld_q   <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            act_q    <= act_i;
            vld_q    <= vld_i;
            sw_q     <= sw_i;
            psum_q   <= psum_d;
            w_q      <= shadow_q;
            acc_q    <= acc_i;
            rvld_q   <= vld_i & col_en_i;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign act_o     = act_q;
    assign vld_o     = vld_q;
    assign sw_o      = sw_q;
    assign psum_o    = psum_q;
    assign w_o       = w_q;
    assign acc_o     = acc_q;
    assign res_vld_o = rvld_q;

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N weight-stationary systolic MAC array: PE grid, column enable, output stage.
// Define SYSTOLIC_OUT_DESKEW_EN to align all columns of a vector at the output.
module systolic_array_nxn #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 2,
    parameter int DATA_W               = 16,
    parameter int COL_SIZE_W           = 16
) (
    input logic                 clk,
    input logic                 rst,
    systolic_array_nxn_if.slave io
);
    import systolic_pkg::*;

    localparam int N = SYSTOLIC_ARRAY_WIDTH;

    logic signed [DATA_W-1:0] act_w  [N][N];
    logic signed [DATA_W-1:0] psum_w [N][N];
    logic signed [DATA_W-1:0] w_w    [N][N];
    logic                     vld_w  [N][N];
    logic                     sw_w   [N][N];
    logic                     acc_w  [N][N];
    logic                     rvld_w [N][N];

    logic [N-1:0]        col_en_q;
    logic [N-1:0]        col_en_d;
    logic [MAX_N-1:0]    mask_full;
    logic                unused_mask;
    logic [N*DATA_W-1:0] data_o;
    logic [N-1:0]        valid_o;

    always_comb begin
        mask_full = col_mask(32'(io.ub_rd_col_size_in), N);
        col_en_d  = col_en_q;
        if (io.ub_rd_col_size_valid_in) begin
            col_en_d = mask_full[N-1:0];
        end
    end

    assign unused_mask = ^mask_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_en_q <= '0;
        end else begin
            col_en_q <= col_en_d;
        end
    end

    // Column 0 also carries valid/switch south so each row sees them skewed.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic signed [DATA_W-1:0] a_in;
            logic signed [DATA_W-1:0] p_in;
            logic signed [DATA_W-1:0] wt_in;
            logic                     v_in;
            logic                     s_in;
            logic                     ac_in;
            logic                     unused_pe;

            if (c == 0) begin : g_west
                assign a_in = io.sys_data_in[r*DATA_W +: DATA_W];
                if (r == 0) begin : g_corner
                    assign v_in = io.sys_start;
                    assign s_in = io.sys_switch_in;
                end else begin : g_down
                    assign v_in = vld_w[r-1][0];
                    assign s_in = sw_w[r-1][0];
                end
            end else begin : g_inner
                assign a_in = act_w[r][c-1];
                assign v_in = vld_w[r][c-1];
                assign s_in = sw_w[r][c-1];
            end

            if (r == 0) begin : g_north
                assign p_in  = '0;
                assign wt_in = io.sys_weight_in[c*DATA_W +: DATA_W];
                assign ac_in = io.sys_accept_w[c];
            end else begin : g_below
                assign p_in  = psum_w[r-1][c];
                assign wt_in = w_w[r-1][c];
                assign ac_in = acc_w[r-1][c];
            end

            pe #(
                .DATA_W(DATA_W)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .col_en_i (col_en_q[c]),
                .act_i    (a_in),
                .vld_i    (v_in),
                .sw_i     (s_in),
                .psum_i   (p_in),
                .w_i      (wt_in),
                .acc_i    (ac_in),
                .act_o    (act_w[r][c]),
                .vld_o    (vld_w[r][c]),
                .sw_o     (sw_w[r][c]),
                .psum_o   (psum_w[r][c]),
                .w_o      (w_w[r][c]),
                .acc_o    (acc_w[r][c]),
                .res_vld_o(rvld_w[r][c])
            );

            assign unused_pe = ^{act_w[r][c], vld_w[r][c], sw_w[r][c],
                                 w_w[r][c], acc_w[r][c], rvld_w[r][c]};
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_out
`ifdef SYSTOLIC_OUT_DESKEW_EN
        localparam int D = N - 1 - c;
        if (D == 0) begin : g_direct
            assign data_o[c*DATA_W +: DATA_W] = psum_w[N-1][c];
            assign valid_o[c]                 = rvld_w[N-1][c];
        end else begin : g_dsk
            logic [DATA_W-1:0] dsk_data_q [D];
            logic              dsk_vld_q  [D];

            // Column c waits N-1-c cycles so the whole vector leaves together.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) begin
                        dsk_data_q[i] <= '0;
                        dsk_vld_q[i]  <= 1'b0;
                    end
                end else begin
                    dsk_data_q[0] <= psum_w[N-1][c];
                    dsk_vld_q[0]  <= rvld_w[N-1][c];
                    for (int i = 1; i < D; i++) begin
                        dsk_data_q[i] <= dsk_data_q[i-1];
                        dsk_vld_q[i]  <= dsk_vld_q[i-1];
                    end
                end
            end

            assign data_o[c*DATA_W +: DATA_W] = dsk_data_q[D-1];
            assign valid_o[c]                 = dsk_vld_q[D-1];
        end
`else
        assign data_o[c*DATA_W +: DATA_W] = psum_w[N-1][c];
        assign valid_o[c]                 = rvld_w[N-1][c];
`endif
    end

    assign io.sys_data_out  = data_o;
    assign io.sys_valid_out = valid_o;

endmodule
